// File: rtl/fifo_pop_counters.sv
// Per-channel pop counters with run/freeze control, wrap or saturate overflow handling,
// sticky overflow flags and a registered request/valid read port with optional clear-on-read.
module fifo_pop_counters #(
   parameter int unsigned NUM_CH   = 5,
   parameter int unsigned CNT_W    = 5,
   parameter int unsigned IDX_W    = 3,
   parameter bit          SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [NUM_CH-1:0] pop,
   input  logic              req,
   input  logic [IDX_W-1:0]  idx,
   input  logic              clear_on_read,
   output logic              valid,
   output logic [CNT_W-1:0]  data_out,
   output logic [NUM_CH-1:0] ovf,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCount = 2'd1,
      StHold  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic              valid_q;
   logic [CNT_W-1:0]  data_q, data_d;
   logic [NUM_CH-1:0] hit;
   logic [CNT_W-1:0]  sel_cnt;
   logic              idx_ok;

   assign idx_ok = (32'(idx) < NUM_CH);
   // Pops only count while running; the registered state makes start/stop act one cycle late.
   assign hit    = (state_q == StCount) ? pop : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start && !stop) state_d = StCount;
         StCount: if (stop)           state_d = StHold;
         StHold:  if (start && !stop) state_d = StCount;
         default:                     state_d = StIdle;
      endcase
   end

   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) sel_cnt = cnt_q[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i];
         if (req && clear_on_read && idx == IDX_W'(i)) begin
            // A pop coinciding with the clearing read survives as the new count.
            cnt_d[i] = CNT_W'(hit[i]);
            ovf_d[i] = 1'b0;
         end else if (hit[i]) begin
            if (cnt_q[i] == CntMax) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = SATURATE ? CntMax : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      data_d = data_q;
      if (req) data_d = idx_ok ? sel_cnt : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ovf_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
         valid_q <= req;
         data_q  <= data_d;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign valid    = valid_q;
   assign data_out = data_q;
   assign ovf      = ovf_q;
   assign state    = state_q;

endmodule

// File: tb/tb_fifo_pop_counters.sv
// Bench for fifo_pop_counters: wrap and saturate instances share stimulus; directed scenarios
// check fixed expected values, a random phase checks against a behavioural model.
module tb_fifo_pop_counters;

   localparam int NUM_CH = 5;
   localparam int CNT_W  = 5;
   localparam int IDX_W  = 3;
   localparam int MOD    = 1 << CNT_W;

   logic              clk;
   logic              reset;
   logic              start;
   logic              stop;
   logic [NUM_CH-1:0] pop;
   logic              req;
   logic [IDX_W-1:0]  idx;
   logic              clear_on_read;

   logic              valid_w, valid_s;
   logic [CNT_W-1:0]  data_w, data_s;
   logic [NUM_CH-1:0] ovf_w, ovf_s;
   logic [1:0]        state_w, state_s;

   int checks   = 0;
   int failures = 0;

   // Behavioural model, index 0 = wrap instance, 1 = saturate instance.
   int m_cnt [2][NUM_CH];
   bit m_ovf [2][NUM_CH];
   int m_data[2];
   bit m_valid;
   int m_state;

   fifo_pop_counters #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(1'b0)) u_dut_wrap (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pop(pop), .req(req), .idx(idx),
      .clear_on_read(clear_on_read), .valid(valid_w), .data_out(data_w), .ovf(ovf_w),
      .state(state_w)
   );

   fifo_pop_counters #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SATURATE(1'b1)) u_dut_sat (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pop(pop), .req(req), .idx(idx),
      .clear_on_read(clear_on_read), .valid(valid_s), .data_out(data_s), .ovf(ovf_s),
      .state(state_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_update();
      bit run;
      run = (m_state == 1);
      if (reset) begin
         for (int s = 0; s < 2; s++) begin
            m_data[s] = 0;
            for (int c = 0; c < NUM_CH; c++) begin
               m_cnt[s][c] = 0;
               m_ovf[s][c] = 0;
            end
         end
         m_valid = 0;
         m_state = 0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (req) m_data[s] = (int'(idx) < NUM_CH) ? m_cnt[s][int'(idx)] : 0;
            for (int c = 0; c < NUM_CH; c++) begin
               if (req && clear_on_read && int'(idx) == c) begin
                  m_cnt[s][c] = (run && pop[c]) ? 1 : 0;
                  m_ovf[s][c] = 0;
               end else if (run && pop[c]) begin
                  m_cnt[s][c] = m_cnt[s][c] + 1;
                  if (m_cnt[s][c] >= MOD) begin
                     m_ovf[s][c] = 1;
                     m_cnt[s][c] = (s == 1) ? MOD - 1 : m_cnt[s][c] % MOD;
                  end
               end
            end
         end
         m_valid = req;
         if (stop) begin
            if (m_state == 1) m_state = 2;
         end else if (start) begin
            m_state = 1;
         end
      end
   endfunction

   function automatic logic [NUM_CH-1:0] model_ovf(int s);
      logic [NUM_CH-1:0] v;
      for (int c = 0; c < NUM_CH; c++) v[c] = m_ovf[s][c];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (state_w !== 2'd0 || valid_w !== 1'b0 || data_w !== '0 || ovf_w !== '0) begin
         failures++;
         $display("FAIL reset_state got st=%0d v=%0b d=%0d ovf=%b exp st=0 v=0 d=0 ovf=0",
                  state_w, valid_w, data_w, ovf_w);
      end
      reset = 1'b0;
      pop   = 5'b00001;
      repeat (3) tick();
      pop = '0;
      req = 1'b1;
      idx = 3'd0;
      tick();
      req = 1'b0;
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd0 || state_w !== 2'd0 || ovf_w !== '0) begin
         failures++;
         $display("FAIL idle_pops_ignored got v=%0b d=%0d st=%0d ovf=%b exp v=1 d=0 st=0 ovf=0",
                  valid_w, data_w, state_w, ovf_w);
      end
      tick();
      checks++;
      if (valid_w !== 1'b0) begin
         failures++;
         $display("FAIL valid_one_cycle got=%0b exp=0", valid_w);
      end
   endtask

   task automatic test_basic_count();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (state_w !== 2'd1) begin
         failures++;
         $display("FAIL start_to_count got=%0d exp=1", state_w);
      end
      pop = 5'b00011;
      tick();
      pop = 5'b00001;
      tick();
      pop = '0;
      req = 1'b1;
      idx = 3'd0;
      tick();
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd2) begin
         failures++;
         $display("FAIL basic_ch0 got v=%0b d=%0d exp v=1 d=2", valid_w, data_w);
      end
      idx = 3'd1;
      tick();
      req = 1'b0;
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd1) begin
         failures++;
         $display("FAIL basic_ch1 got v=%0b d=%0d exp v=1 d=1", valid_w, data_w);
      end
      tick();
      checks++;
      if (valid_w !== 1'b0 || data_w !== 5'd1) begin
         failures++;
         $display("FAIL data_hold got v=%0b d=%0d exp v=0 d=1", valid_w, data_w);
      end
   endtask

   task automatic test_freeze();
      pop = 5'b00100;
      repeat (3) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (3) tick();
      pop = '0;
      req = 1'b1;
      idx = 3'd2;
      tick();
      req = 1'b0;
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd4 || state_w !== 2'd2) begin
         failures++;
         $display("FAIL freeze_hold got v=%0b d=%0d st=%0d exp v=1 d=4 st=2",
                  valid_w, data_w, state_w);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      pop = 5'b00100;
      tick();
      pop = '0;
      req = 1'b1;
      tick();
      req = 1'b0;
      checks++;
      if (data_w !== 5'd5 || state_w !== 2'd1) begin
         failures++;
         $display("FAIL freeze_resume got d=%0d st=%0d exp d=5 st=1", data_w, state_w);
      end
   endtask

   task automatic test_wrap_saturate();
      pop = 5'b01000;
      repeat (33) tick();
      pop = '0;
      req = 1'b1;
      idx = 3'd3;
      tick();
      req = 1'b0;
      checks++;
      if (data_w !== 5'd1 || ovf_w[3] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_ch3 got d=%0d ovf3=%0b exp d=1 ovf3=1", data_w, ovf_w[3]);
      end
      checks++;
      if (data_s !== 5'd31 || ovf_s[3] !== 1'b1) begin
         failures++;
         $display("FAIL sat_ch3 got d=%0d ovf3=%0b exp d=31 ovf3=1", data_s, ovf_s[3]);
      end
      req           = 1'b1;
      clear_on_read = 1'b1;
      tick();
      req           = 1'b0;
      clear_on_read = 1'b0;
      checks++;
      if (ovf_w[3] !== 1'b0 || ovf_s[3] !== 1'b0 || data_w !== 5'd1 || data_s !== 5'd31) begin
         failures++;
         $display("FAIL ovf_clear got ovf3 w=%0b s=%0b d w=%0d s=%0d exp 0 0 1 31",
                  ovf_w[3], ovf_s[3], data_w, data_s);
      end
   endtask

   task automatic test_clear_on_read();
      pop = 5'b10000;
      repeat (7) tick();
      req           = 1'b1;
      idx           = 3'd4;
      clear_on_read = 1'b1;
      tick();
      clear_on_read = 1'b0;
      pop           = '0;
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd7) begin
         failures++;
         $display("FAIL cor_first got v=%0b d=%0d exp v=1 d=7", valid_w, data_w);
      end
      tick();
      req = 1'b0;
      checks++;
      if (data_w !== 5'd1 || data_s !== 5'd1 || ovf_w[4] !== 1'b0) begin
         failures++;
         $display("FAIL cor_coincident_pop got d w=%0d s=%0d ovf4=%0b exp d=1 ovf4=0",
                  data_w, data_s, ovf_w[4]);
      end
   endtask

   task automatic test_oob_and_reset();
      req = 1'b1;
      idx = 3'd6;
      tick();
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd0) begin
         failures++;
         $display("FAIL oob_read got v=%0b d=%0d exp v=1 d=0", valid_w, data_w);
      end
      idx = 3'd0;
      tick();
      checks++;
      if (data_w !== 5'd2) begin
         failures++;
         $display("FAIL oob_no_change got=%0d exp=2", data_w);
      end
      idx = 3'd1;
      tick();
      req   = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (valid_w !== 1'b0 || state_w !== 2'd0 || ovf_w !== '0 || data_w !== '0) begin
         failures++;
         $display("FAIL midop_reset got v=%0b st=%0d ovf=%b d=%0d exp v=0 st=0 ovf=0 d=0",
                  valid_w, state_w, ovf_w, data_w);
      end
      req = 1'b1;
      idx = 3'd0;
      tick();
      req = 1'b0;
      checks++;
      if (valid_w !== 1'b1 || data_w !== 5'd0) begin
         failures++;
         $display("FAIL reset_clears_cnt got v=%0b d=%0d exp v=1 d=0", valid_w, data_w);
      end
   endtask

   task automatic test_random();
      logic              g_valid;
      logic [CNT_W-1:0]  g_data;
      logic [NUM_CH-1:0] g_ovf;
      logic [1:0]        g_state;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         start         = ($urandom_range(0, 9) == 0);
         stop          = ($urandom_range(0, 39) == 0);
         pop           = NUM_CH'($urandom);
         req           = ($urandom_range(0, 2) == 0);
         idx           = IDX_W'($urandom_range(0, 7));
         clear_on_read = ($urandom_range(0, 7) == 0);
         reset         = ($urandom_range(0, 799) == 0);
         tick();
         for (int s = 0; s < 2; s++) begin
            g_valid = s ? valid_s : valid_w;
            g_data  = s ? data_s  : data_w;
            g_ovf   = s ? ovf_s   : ovf_w;
            g_state = s ? state_s : state_w;
            checks++;
            if (g_valid !== m_valid || int'(g_data) != m_data[s] || g_ovf !== model_ovf(s) ||
                int'(g_state) != m_state) begin
               failures++;
               $display("FAIL rnd_sat%0d cyc=%0d got v=%0b d=%0d ovf=%b st=%0d exp v=%0b d=%0d ovf=%b st=%0d",
                        s, cyc, g_valid, g_data, g_ovf, g_state, m_valid, m_data[s],
                        model_ovf(s), m_state);
            end
         end
      end
      start         = 1'b0;
      stop          = 1'b0;
      pop           = '0;
      req           = 1'b0;
      clear_on_read = 1'b0;
      reset         = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      stop          = 1'b0;
      pop           = '0;
      req           = 1'b0;
      idx           = '0;
      clear_on_read = 1'b0;
      test_reset();
      test_basic_count();
      test_freeze();
      test_wrap_saturate();
      test_clear_on_read();
      test_oob_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_pop_counters.md
# fifo_pop_counters

Parametrised bank of per-channel pop counters that tallies pop strobes from NUM_CH FIFOs and returns any selected count through a request/valid read port. It sits beside the FIFO array in the datapath, taps the pop lines, and is read by the test/monitor logic. Over the five-channel, fixed-width counter block it adds:

- configurable channel count and counter width;
- a run/freeze state machine;
- wrap or saturate mode with sticky overflow flags;
- clear-on-read.

## Interface
- NUM_CH, default 5: number of FIFO channels/counters.
- CNT_W, default 5: counter width in bits.
- IDX_W, default 3: idx width; must satisfy 2^IDX_W >= NUM_CH.
- SATURATE, default 0: 0 = wrap at max, 1 = hold at max.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  enter/resume counting.
- stop  in  1  freeze counters.
- pop  in  NUM_CH  per-channel pop strobe; one count per cycle high.
- req  in  1  read request, sampled with idx.
- idx  in  IDX_W  channel to read.
- clear_on_read  in  1  sampled with req; clears the read channel.
- valid  out  1  one-cycle read response strobe.
- data_out  out  CNT_W  read count, meaningful when valid=1.
- ovf  out  NUM_CH  sticky per-channel overflow flags.
- state  out  2  FSM state: IDLE=0, COUNT=1, HOLD=2.

## Operation
- Reset, at a clk edge with reset=1, sets:
  - all counters to 0, ovf to 0, valid to 0, data_out to 0;
  - state to IDLE.
- Reset mid-operation has the same effect. Any pending response is dropped.
- FSM:
  - IDLE --start--> COUNT.
  - COUNT --stop--> HOLD.
  - HOLD --start--> COUNT.
  - If start and stop are both high, stop wins. In IDLE, stop alone keeps IDLE.
  - There is no return to IDLE except reset.
- Counting happens only in COUNT. Each channel with pop[i]=1 increments by 1. In IDLE and HOLD, pops are ignored.
- Overflow, when a counter at 2^CNT_W-1 receives a pop:
  - SATURATE=0: it wraps to 0.
  - SATURATE=1: it stays at max.
  - In both modes ovf[i] is set and remains set until reset or a clear-on-read of channel i.
- Reads are allowed in every state, including IDLE and HOLD.
- A req with idx<NUM_CH returns counter[idx]. A req with idx>=NUM_CH returns data_out=0 with valid=1, and nothing is cleared.
- Clear-on-read: counter[idx] is set to (pop[idx] and state==COUNT ? 1 : 0), and ovf[idx] is cleared. The pop coinciding with the read is never lost.
- Back-to-back req every cycle is legal; each produces its own valid pulse.

## Timing
- req, idx, clear_on_read are sampled at edge N.
- At edge N+1: valid=1 and data_out = counter value as it was before edge N's update. The pop arriving in the same cycle as req is excluded from that response.
- valid falls at edge N+2 unless a new req was sampled at N+1.
- data_out holds its last value when valid=0.
- A pop at edge N is visible in a read requested at edge N+1 or later, giving 2-cycle pop-to-data latency.
- start/stop take effect on the cycle after sampling. A pop in the same cycle as start (from IDLE/HOLD) is not counted. A pop in the same cycle as stop (from COUNT) is counted.
- ovf[i] updates at the same edge as the overflowing pop.
- state output is registered and changes at the sampling edge.

## Test plan
Defaults: NUM_CH=5, CNT_W=5, SATURATE=0 unless stated.

- **Reset and idle:** hold reset 2 cycles, then pulse pop[0] 3 cycles in IDLE and read idx=0 → valid one cycle, data_out=0, state=0, ovf=0.
- **Basic count and latency:** start, then pop_0 high 2 cycles, pop_1 high 1 cycle; req idx=0 then idx=1 back-to-back → consecutive valid pulses returning 2 then 1, the first valid two edges after the last pop.
- **Freeze:** in COUNT, pop[2] 4 cycles; stop asserted in the same cycle as the 4th pop; then 3 more pops in HOLD → read idx=2 returns 4, state=2; start again, then 1 pop → read returns 5.
- **Wrap vs saturate:** 33 pops on channel 3 with SATURATE=0 → data_out=1, ovf[3]=1. Repeat with SATURATE=1 → data_out=31, ovf[3]=1.
- **Clear-on-read with coincident pop:** channel 4 at 7; req idx=4 with clear_on_read=1 while pop[4]=1 → response 7; next read returns 1; ovf[4]=0.
- **Out-of-range and mid-op reset:** req idx=6 → valid=1, data_out=0, no counter changes. Assert reset in the cycle after a req → no valid pulse; all counters 0; state=IDLE.
